// File: rtl/intr_ctrl_multi.sv
// Multi-source interrupt controller: synchronises N_CH lines, latches edge or level requests,
// masks and arbitrates them, and presents one vectored request at a time to the core.
module intr_ctrl_multi #(
  parameter int unsigned       N_CH        = 4,
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] VEC_BASE    = 8'h01,
  parameter int unsigned       VEC_STRIDE  = 1,
  parameter logic [N_CH-1:0]   EDGE_MODE   = {N_CH{1'b1}},
  parameter bit                ROUND_ROBIN = 1'b0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [N_CH-1:0]   MASK_RST    = {N_CH{1'b0}},
  localparam int unsigned      ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   irq_in,
  input  logic              mask_we,
  input  logic [N_CH-1:0]   mask_wdata,
  input  logic              intr_ack,
  input  logic              rti_done,
  output logic              intr_req,
  output logic [ADDR_W-1:0] intr_vec,
  output logic [ID_W-1:0]   active_id,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   mask,
  output logic              in_service
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StSvc  = 2'd2;

  logic [1:0]                       state_q, state_d;
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0]                  irq_hist_q, irq_hist_d;
  logic [N_CH-1:0]                  pending_q, pending_d;
  logic [N_CH-1:0]                  mask_q, mask_d;
  logic [ID_W-1:0]                  active_id_q, active_id_d;
  logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]                intr_vec_q, intr_vec_d;

  logic [N_CH-1:0] irq_s;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] ack_clr;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic            ack_take;

  assign irq_s      = sync_q[SYNC_STAGES-1];
  assign irq_hist_d = irq_s;
  assign eligible   = pending_q & ~mask_q;
  assign ack_take   = (state_q == StReq) && intr_ack;
  assign mask_d     = mask_we ? mask_wdata : mask_q;

  always_comb begin
    sync_d    = '0;
    sync_d[0] = irq_in;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // A fresh edge in the ack cycle re-sets the bit, so no edge is ever lost.
  always_comb begin
    ack_clr   = '0;
    pending_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ack_clr[i] = ack_take && (active_id_q == ID_W'(i));
      if (EDGE_MODE[i]) begin
        pending_d[i] = (irq_s[i] & ~irq_hist_q[i]) | (pending_q[i] & ~ack_clr[i]);
      end else begin
        pending_d[i] = irq_s[i];
      end
    end
  end

  // Scan from the rotating pointer in RR mode, from index 0 otherwise.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = ROUND_ROBIN ? ((32'(rr_ptr_q) + k) % N_CH) : k;
      if (!win_vld && eligible[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    intr_vec_d  = intr_vec_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d     = StReq;
          active_id_d = win_id;
          intr_vec_d  = VEC_BASE + ADDR_W'(32'(win_id) * VEC_STRIDE);
        end
      end
      StReq: begin
        if (intr_ack) begin
          state_d = StSvc;
          if (ROUND_ROBIN) begin
            rr_ptr_d = ID_W'((32'(active_id_q) + 1) % N_CH);
          end
        end else if (!eligible[active_id_q]) begin
          state_d = StIdle;
        end
      end
      StSvc: begin
        if (rti_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      irq_hist_q  <= '0;
      pending_q   <= '0;
      mask_q      <= MASK_RST;
      active_id_q <= '0;
      rr_ptr_q    <= '0;
      intr_vec_q  <= VEC_BASE;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      irq_hist_q  <= irq_hist_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      active_id_q <= active_id_d;
      rr_ptr_q    <= rr_ptr_d;
      intr_vec_q  <= intr_vec_d;
    end
  end

  assign intr_req   = (state_q == StReq);
  assign in_service = (state_q == StSvc);
  assign intr_vec   = intr_vec_q;
  assign active_id  = active_id_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule
